// File: rtl/chart_recorder.sv
// chart_recorder: timestamps one key's press/release events into a 256-word chart RAM.
// Ports: Clk, Reset (async, active-high); frame_tick advances the frame timer; rec_en gates
// recording; clear wipes timer/count/flags; key_down is the raw key level; rd_addr selects
// key_1..key_4 = words rd_addr..rd_addr+3 (zero at or past count, 1 Clk latency);
// count = words stored; overflow = sticky dropped-event flag; busy = word write in progress.
module chart_recorder #(
    parameter int DEPTH    = 256,
    parameter int HOLD_MIN = 18,
    parameter int TIME_W   = 14
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        rec_en,
    input  logic        clear,
    input  logic        key_down,
    input  logic [7:0]  rd_addr,
    output logic [15:0] key_1,
    output logic [15:0] key_2,
    output logic [15:0] key_3,
    output logic [15:0] key_4,
    output logic [8:0]  count,
    output logic        overflow,
    output logic        busy
);
    localparam logic [8:0]        CNT_MAX  = 9'(DEPTH);
    localparam logic [8:0]        CNT_HOLD = 9'(DEPTH - 2);
    localparam logic [TIME_W-1:0] HMIN     = TIME_W'(HOLD_MIN);

    typedef enum logic [2:0] {IDLE, HELD, WR_TAP, WR_HSTART, WR_HEND} state_t;

    state_t             state, state_n;
    logic [TIME_W-1:0]  timer, timer_n, p_time, p_n, r_time, r_n, pend_time, pt_n, dur;
    logic               pending, pend_n, ovf_n, we, tap, rise, fall;
    logic [8:0]         count_n;
    logic [2:0]         sync, sync_n;
    logic [15:0]        wdata;
    logic [15:0]        mem [DEPTH];
    logic [3:0][7:0]    ridx;
    logic [3:0][15:0]   key_q, key_n;

    // sync[1] is the synchronised level, sync[2] its previous value
    assign rise  = sync[1] & ~sync[2];
    assign fall  = ~sync[1] & sync[2];
    assign busy  = state == WR_TAP || state == WR_HSTART || state == WR_HEND;
    assign dur   = timer - p_time;
    assign tap   = dur < HMIN;
    assign key_1 = key_q[0];
    assign key_2 = key_q[1];
    assign key_3 = key_q[2];
    assign key_4 = key_q[3];

    always_comb begin
        state_n = state;
        p_n     = p_time;
        r_n     = r_time;
        pend_n  = pending;
        pt_n    = pend_time;
        ovf_n   = overflow;
        we      = 1'b0;
        wdata   = '0;
        case (state)
            IDLE: if (rise && rec_en) begin
                state_n = HELD;
                p_n     = timer;
            end
            // space is checked for the whole event here so a hold is never split
            HELD: if (fall || !rec_en) begin
                r_n = timer;
                if (tap ? count < CNT_MAX : count <= CNT_HOLD) state_n = tap ? WR_TAP : WR_HSTART;
                else begin
                    state_n = IDLE;
                    ovf_n   = 1'b1;
                end
            end
            WR_TAP: begin
                we      = 1'b1;
                wdata   = {2'b00, p_time};
                state_n = IDLE;
            end
            WR_HSTART: begin
                we      = 1'b1;
                wdata   = {2'b01, p_time};
                state_n = WR_HEND;
            end
            WR_HEND: begin
                we      = 1'b1;
                wdata   = {2'b10, r_time};
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // a press arriving while writing is remembered and resumed as HELD afterwards
        if (busy && rise && rec_en && !pending) begin
            pend_n = 1'b1;
            pt_n   = timer;
        end
        if (busy && state_n == IDLE && pend_n) begin
            state_n = HELD;
            p_n     = pt_n;
            pend_n  = 1'b0;
        end
        timer_n = frame_tick && rec_en && timer != '1 ? timer + TIME_W'(1) : timer;
        count_n = count + 9'(we);
        sync_n  = {sync[1:0], key_down};
        if (clear) begin
            state_n = IDLE;
            p_n     = '0;
            r_n     = '0;
            pt_n    = '0;
            pend_n  = 1'b0;
            ovf_n   = 1'b0;
            we      = 1'b0;
            timer_n = '0;
            count_n = '0;
            sync_n  = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ridx[i]  = rd_addr + 8'(i);
            key_n[i] = !clear && {1'b0, ridx[i]} < count ? mem[ridx[i]] : '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            timer     <= '0;
            p_time    <= '0;
            r_time    <= '0;
            pend_time <= '0;
            pending   <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            sync      <= '0;
            key_q     <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            p_time    <= p_n;
            r_time    <= r_n;
            pend_time <= pt_n;
            pending   <= pend_n;
            overflow  <= ovf_n;
            count     <= count_n;
            sync      <= sync_n;
            key_q     <= key_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (we) mem[count[7:0]] <= wdata;
    end
endmodule

// File: tb/tb_chart_recorder.sv
// tb_chart_recorder: directed and random record sequences compared with a queue-based chart model.
module tb_chart_recorder;
    logic        Clk = 1'b0;
    logic        Reset, frame_tick, rec_en, clear, key_down;
    logic [7:0]  rd_addr;
    logic [15:0] key_1, key_2, key_3, key_4;
    logic [8:0]  count;
    logic        overflow, busy;

    int          n_chk = 0, n_pass = 0, n_fail = 0;
    logic [15:0] mq[$];
    logic        m_ovf, m_held;
    int          m_timer, m_p;

    chart_recorder dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .rec_en(rec_en), .clear(clear),
        .key_down(key_down), .rd_addr(rd_addr), .key_1(key_1), .key_2(key_2), .key_3(key_3),
        .key_4(key_4), .count(count), .overflow(overflow), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_held  = 1'b0;
        m_timer = 0;
    endtask

    function automatic logic [15:0] exp_word(int i);
        int k = i % 256;
        return k < mq.size() ? mq[k] : 16'h0000;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (rec_en && m_timer < 16383) m_timer++;
        end
    endtask

    task automatic finalize(output int eb);
        int d = m_timer - m_p;
        eb = 0;
        if (d < 18) begin
            if (mq.size() < 256) begin
                mq.push_back({2'b00, 14'(m_p)});
                eb = 1;
            end else m_ovf = 1'b1;
        end else if (mq.size() <= 254) begin
            mq.push_back({2'b01, 14'(m_p)});
            mq.push_back({2'b10, 14'(m_timer)});
            eb = 2;
        end else m_ovf = 1'b1;
        m_held = 1'b0;
    endtask

    task automatic observe(int eb, string tag);
        int nb = 0;
        repeat (8) begin
            step();
            nb += int'(busy);
        end
        check({tag, " busy cycles"}, nb, eb);
        check({tag, " count"}, count, mq.size());
        check({tag, " overflow"}, overflow, m_ovf);
    endtask

    task automatic press();
        key_down = 1'b1;
        repeat (5) step();
        if (rec_en && !m_held) begin
            m_held = 1'b1;
            m_p    = m_timer;
        end
    endtask

    task automatic release_key(string tag);
        int eb = 0;
        key_down = 1'b0;
        if (m_held) finalize(eb);
        observe(eb, tag);
    endtask

    task automatic drop_en(string tag);
        int eb = 0;
        rec_en = 1'b0;
        if (m_held) finalize(eb);
        observe(eb, tag);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
    endtask

    task automatic check_mem(int a, string tag);
        rd_addr = 8'(a);
        step();
        check({tag, " key_1"}, key_1, exp_word(a));
        check({tag, " key_2"}, key_2, exp_word(a + 1));
        check({tag, " key_3"}, key_3, exp_word(a + 2));
        check({tag, " key_4"}, key_4, exp_word(a + 3));
    endtask

    initial begin
        logic found;
        Reset = 1'b1; frame_tick = 1'b0; rec_en = 1'b0; clear = 1'b0; key_down = 1'b0; rd_addr = '0;
        model_reset();
        repeat (2) step();
        check("reset count", count, 0);
        check("reset overflow", overflow, 0);
        check("reset busy", busy, 0);
        check("reset key_1", key_1, 0);
        Reset = 1'b0;
        step();

        rec_en = 1'b1;
        tick(71);
        press();
        tick(9);
        release_key("tap");
        check_mem(0, "tap read");
        check("tap word", key_1, 16'h0047);

        do_clear();
        tick(619);
        press();
        tick(28);
        release_key("hold");
        check_mem(0, "hold read");
        check("hold start word", key_1, 16'h426B);
        check("hold end word", key_2, 16'h8287);

        tick(5);
        press();
        tick(17);
        release_key("dur17");
        press();
        tick(18);
        release_key("dur18");
        check_mem(2, "threshold read");

        press();
        tick(25);
        drop_en("rec_en drop");
        rec_en = 1'b1;
        release_key("fall in idle");

        for (int i = 0; i < 30; i++) begin
            tick($urandom_range(0, 10));
            press();
            tick($urandom_range(0, 40));
            release_key("random");
        end
        for (int a = 0; a < mq.size() + 4; a += 4) check_mem(a, "random read");

        press();
        clear = 1'b1;
        step();
        key_down = 1'b0;
        step();
        clear = 1'b0;
        model_reset();
        observe(0, "clear in held");
        tick(3);
        press();
        release_key("after clear");
        check_mem(0, "after clear read");

        press();
        tick(20);
        key_down = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = busy;
        end
        check("reach write state", found, 1);
        #2 Reset = 1'b1;
        #1;
        check("async reset count", count, 0);
        check("async reset busy", busy, 0);
        check("async reset key_1", key_1, 0);
        step();
        Reset = 1'b0;
        model_reset();
        observe(0, "after reset");

        tick(20000);
        press();
        drop_en("saturated");
        check_mem(0, "saturated read");
        check("saturated word", key_1, 16'h3FFF);
        rec_en = 1'b1;
        release_key("saturated release");

        do_clear();
        for (int i = 0; i < 255; i++) begin
            tick(1);
            press();
            release_key("fill");
        end
        press();
        tick(20);
        release_key("full hold");
        check("full hold count", count, 255);
        press();
        release_key("last tap");
        press();
        release_key("tap when full");
        check("full count", count, 256);
        check("full overflow", overflow, 1);
        check_mem(253, "wrap read");

        do_clear();
        step();
        check("clear count", count, 0);
        check("clear overflow", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/chart_recorder.md
Name: chart_recorder

Overview:
- Record side of the note-chart format. Samples one player key and timestamps press/release events with the frame tick.
- Packs each event into the 16-bit chart word: [15:14] type (00 tap, 01 hold start, 10 hold end), [13:0] frame time.
- Stores words in time order in an internal 256-entry RAM.
- Read port returns four consecutive words per address, so a recorded chart can be replayed by the same note-scroll/judge logic that reads the fixed charts.

Parameters:
- DEPTH, 256, number of chart words; address width is 8.
- HOLD_MIN, 18, minimum press duration in frames that records as a hold (01/10 pair) instead of a tap (00).
- TIME_W, 14, frame-time field width; fixed by the chart word format.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-Clk pulse per video frame (~60 Hz); advances the timer.
- rec_en  in  1  recording enable; the timer runs and events are captured only while high.
- clear  in  1  synchronous clear of chart contents, timer, and flags.
- key_down  in  1  raw asynchronous key level, 1 = pressed.
- rd_addr  in  8  read address.
- key_1  out  16  word at rd_addr.
- key_2  out  16  word at rd_addr+1.
- key_3  out  16  word at rd_addr+2.
- key_4  out  16  word at rd_addr+3.
- count  out  9  number of valid words stored, 0..256.
- overflow  out  1  sticky; an event was dropped because the RAM was full.
- busy  out  1  high while the FSM is in a WR_* state.

Behaviour:
- Reset (async) and clear (sync) both produce:
  - timer=0, count=0, overflow=0, FSM=IDLE, pending=0.
  - key_1..key_4=0, busy=0.
  - Sync flops cleared.
  - RAM contents are not cleared.
- Input sync:
  - key_down passes through 2 flops.
  - A rise or fall is detected on the synced level against its previous value.
  - Press-to-detect latency is 3 Clk.
- Timer:
  - 14 bits; increments on frame_tick while rec_en=1.
  - Saturates at 16383 and never wraps.
- FSM states and transitions:
  - IDLE: on rise with rec_en=1, capture p_time=timer and go to HELD.
  - HELD: on fall, capture r_time=timer. If (r_time − p_time) < HOLD_MIN go to WR_TAP, else go to WR_HSTART.
  - HELD: if rec_en drops, treat it as a fall at the current timer value.
  - WR_TAP: write {00, p_time}, then go to IDLE.
  - WR_HSTART: write {01, p_time}, then go to WR_HEND.
  - WR_HEND: write {10, r_time}, then go to IDLE.
  - A write stores to mem[count] and increments count. Each write takes 1 Clk; busy=1 in WR_* states.
- Rise during a WR_* state:
  - Set pending=1 and latch the press time at the edge.
  - On leaving WR_* go directly to HELD with that press time and clear pending.
- Full handling (decided before the first write of the event):
  - A tap needs 1 free entry; a hold needs 2. Holds are never split.
  - If space is insufficient: no write, count unchanged, overflow=1 (sticky until reset/clear), FSM goes to IDLE.
- A fall in IDLE is ignored (press occurred before rec_en).
- Simultaneous clear and write: clear wins.
- Read port:
  - Registered, 1 Clk latency.
  - key_n = mem[(rd_addr+n−1) mod 256] when that index is < count, else 16'h0000.
  - The comparison uses count as sampled in the same cycle.

Test Plan:
- Tap: rec_en=1, press at timer=71, release at timer=80 → one word 16'h0047 at index 0, count=1; rd_addr=0 gives key_1=16'h0047, key_2=0 one Clk later.
- Hold: press at timer=619, release at timer=647 (duration 28 ≥ 18) → index0=16'h426B, index1=16'h8287, count=2, busy high for exactly 2 Clk.
- Threshold edges: duration 17 → tap word only; duration 18 → hold pair.
- Full: fill to count=255, then record a hold → no write, count=255, overflow=1; a following tap writes index 255, count=256; any further tap leaves count=256 and overflow=1.
- Timer saturation and rec_en drop: run 20000 frame_ticks → timer=16383; press then drop rec_en with key still held → hold pair with both times 16383 if duration ≥ HOLD_MIN, else tap 16'h3FFF.
- Reset/clear mid-operation: assert Reset in WR_HSTART → count=0, outputs 0, no hold-end word written; clear during HELD → FSM=IDLE, later release ignored.
